// File: rtl/vga_pkg.sv
// Shared VGA definitions: default resolution, colour index codes and the
// frame-fetch FSM state encoding.
package vga_pkg;

  localparam int H_RES_DEF    = 640;
  localparam int V_RES_DEF    = 480;
  localparam int FRAME_PIXELS = H_RES_DEF * V_RES_DEF;

  typedef enum logic [2:0] {
    BLACK  = 3'd0,
    GREEN  = 3'd1,
    BLUE   = 3'd2,
    RED    = 3'd3,
    TEAL   = 3'd4,
    GRAY   = 3'd5,
    WHITE  = 3'd6,
    GWHITE = 3'd7
  } cidx_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry skid FIFO holding colour indices between the frame-buffer read
// return and the pixel FIFO write port.
module fetch_skid_buf #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone qualifies which entries hold data.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/frame_fetch.sv
// Raster-order frame-buffer fetcher feeding the VGA pixel FIFO with backpressure.
// Build option: FRAME_FETCH_TEST_PATTERN_EN replaces RAM reads with 8 colour bars.
module frame_fetch
  import vga_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 19,
  parameter int CIDX_W = 3
) (
  input  logic              clk_100mhz_buf,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [CIDX_W-1:0] fb_rdata,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [CIDX_W-1:0] Wdata,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  fetch_state_e      state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q;

  logic              rd_issue;
  logic              last_pix;
  logic [2:0]        occ_next;
  logic [CIDX_W-1:0] push_data;
  logic [CIDX_W-1:0] skid_head;
  logic              skid_full, skid_empty;
  logic [1:0]        skid_count;

  // Occupancy net of this cycle's write, so reads keep streaming at 1 pixel/cycle
  // yet a full FIFO can never push more than two data into the skid buffer.
  assign occ_next = 3'(skid_count) + 3'(inflight_q) - 3'(wr_en);
  assign rd_issue = (state_q == FETCH) && !skid_full && (occ_next < 3'd2);
  assign last_pix = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

  assign wr_en      = ~fifo_full & ~skid_empty;
  assign Wdata      = skid_empty ? '0 : skid_head;
  assign fb_addr    = addr_q;
  assign busy       = (state_q == FETCH) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);

`ifdef FRAME_FETCH_TEST_PATTERN_EN
  localparam int BAR_W = (H_RES >= 8) ? (H_RES / 8) : 1;

  logic [CIDX_W-1:0] pat_q, pat_d;

  // Pattern value travels with the pseudo-read so timing matches a RAM fetch.
  always_comb begin
    pat_d = pat_q;
    if (rd_issue) pat_d = CIDX_W'((int'(x_q) / BAR_W) % 8);
  end

  always_ff @(posedge clk_100mhz_buf) begin
    if (!rst_n) pat_q <= '0;
    else        pat_q <= pat_d;
  end

  assign fb_rd     = 1'b0;
  assign push_data = pat_q;
`else
  assign fb_rd     = rd_issue;
  assign push_data = fb_rdata;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FETCH;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      FETCH: begin
        if (rd_issue) begin
          if (last_pix) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == XW'(H_RES - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (occ_next == 3'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz_buf) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      inflight_q <= rd_issue;
    end
  end

  fetch_skid_buf #(
    .W(CIDX_W)
  ) u_skid (
    .clk       (clk_100mhz_buf),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (wr_en),
    .head_data (skid_head),
    .full      (skid_full),
    .empty     (skid_empty),
    .count     (skid_count)
  );

endmodule

// File: tb/tb_frame_fetch.sv
// Scoreboard bench for frame_fetch on an 8x4 frame with a 1-cycle RAM model.
module tb_frame_fetch;

  localparam int H = 8;
  localparam int V = 4;
  localparam int NPIX = H * V;
  localparam logic [2:0] PAT [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [18:0] fb_addr;
  logic        fb_rd;
  logic [2:0]  fb_rdata = 3'd0;
  logic        fifo_full;
  logic        wr_en;
  logic [2:0]  Wdata;
  logic        busy;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, start_cyc = 0, first_wr = 0, last_wr = 0, done_cyc = 0;
  int done_count = 0, wr_count = 0, wr_total = 0, exp_addr = 0, last_rd_addr = 0;
  bit throttle_en = 1'b0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  frame_fetch #(.H_RES(H), .V_RES(V)) dut (
    .clk_100mhz_buf (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .fb_addr        (fb_addr),
    .fb_rd          (fb_rd),
    .fb_rdata       (fb_rdata),
    .fifo_full      (fifo_full),
    .wr_en          (wr_en),
    .Wdata          (Wdata),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  // Frame-buffer RAM: pixel at address a holds colour a[2:0].
  always @(posedge clk) if (fb_rd) fb_rdata <= fb_addr[2:0];

  always @(posedge clk) begin
    #1;
    if (throttle_en) fifo_full = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    cyc++;
    if (frame_start && !busy && !frame_done && rst_n) begin
      start_cyc  = cyc;
      wr_count   = 0;
      done_count = 0;
    end
    if (wr_en) begin
      check("wr_en_while_full", 32'(fifo_full), 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got Wdata=%0d with empty scoreboard", Wdata);
      end else begin
        check("wdata", 32'(Wdata), 32'(exp_q.pop_front()));
      end
      if (wr_count == 0) first_wr = cyc;
      last_wr = cyc;
      wr_count++;
      wr_total++;
    end
    if (fb_rd) begin
      check("fb_addr", 32'(fb_addr), exp_addr);
      check("fb_addr_range", 32'(fb_addr <= 19'(NPIX - 1)), 32'd1);
      exp_addr++;
      last_rd_addr = int'(fb_addr);
    end
    if (frame_done) begin
      done_cyc = cyc;
      done_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame();
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(PAT[i % 8]);
    exp_addr    = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!frame_done && n < budget) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      tick();
      n++;
    end
    check("write_count_reached", 32'(wr_count >= target), 32'd1);
  endtask

  task automatic check_frame_complete(input string tag);
    check({tag, "_writes"}, wr_count, NPIX);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
    check({tag, "_done_pulses"}, done_count, 1);
    check({tag, "_last_addr"}, last_rd_addr, NPIX - 1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    fifo_full   = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_rd", 32'(fb_rd), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wdata", 32'(Wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_no_writes", wr_total, 0);
    check("idle_busy", 32'(busy), 32'd0);

    // Unthrottled frame, plus a frame_start landing in the DONE cycle
    start_frame();
    wait_done(200);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    check("first_write_latency", first_wr - start_cyc, 3);
    check("writes_back_to_back", last_wr - first_wr, NPIX - 1);
    check("done_after_last_write", done_cyc - last_wr, 1);
    check_frame_complete("unthrottled");

    // Random backpressure
    throttle_en = 1'b1;
    start_frame();
    wait_done(3000);
    throttle_en = 1'b0;
    fifo_full   = 1'b0;
    repeat (3) tick();
    check_frame_complete("throttled");

    // frame_start while busy is ignored
    start_frame();
    wait_writes(10, 200);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(200);
    repeat (3) tick();
    check_frame_complete("restart_ignored");

    // Back-to-back second frame
    start_frame();
    wait_done(200);
    repeat (3) tick();
    check_frame_complete("second_frame");

    // Reset mid-frame, then a fresh frame from address 0
    start_frame();
    wait_writes(15, 200);
    rst_n = 1'b0;
    tick();
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fb_rd", 32'(fb_rd), 32'd0);
    check("midrst_fb_addr", 32'(fb_addr), 32'd0);
    rst_n = 1'b1;
    snap  = wr_total;
    repeat (8) tick();
    check("midrst_no_writes", wr_total, snap);
    start_frame();
    wait_done(200);
    repeat (3) tick();
    check("post_rst_latency", first_wr - start_cyc, 3);
    check_frame_complete("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
